// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom: instruction memory sitting beside the core on its fetch interface.
//
// Fetch side: the byte address on rv32core_pc_i is sampled on every rising
// edge. The word for that address shows up on rom_inst_o one cycle later, so it
// lines up with the PC held in the IF/ID pipeline register. Misaligned or
// out-of-range fetches return NOP_INST and raise rom_addr_err_o. While a load
// is in progress every fetch returns NOP_INST with valid and err both low.
//
// Loader side: a valid/ready write port fills the array in order, starting at
// word 0. ld_start_i opens a load, and ld_last_i marks the final word. If the
// loader offers a word after the array is full, ld_ovf_o is set and the load
// ends.
//
// Ports
//   clk               rising-edge clock for all logic
//   rst               synchronous, active-high reset
//   rv32core_pc_i     fetch byte address
//   rom_inst_o        instruction for the PC sampled on the previous edge
//   rom_inst_valid_o  rom_inst_o holds a real array word
//   rom_addr_err_o    previous fetch was misaligned or out of range
//   ld_start_i        one-cycle pulse, begins a load at word 0 (IDLE only)
//   ld_data_i         word to write
//   ld_valid_i        ld_data_i is valid
//   ld_last_i         marks the final word of a load (qualified by ld_valid_i)
//   ld_ready_o        loader can accept a word this cycle
//   ld_busy_o         load in progress
//   ld_done_o         one-cycle pulse when a load ends
//   ld_ovf_o          sticky: the last load overran DEPTH
//   ld_state_o        debug view of the loader FSM (0 IDLE, 1 LOAD, 2 DONE)
//
// Handshake: a word transfers on a rising edge where ld_valid_i and ld_ready_o
// are both high. ld_ready_o depends only on the FSM state and the word counter,
// never on ld_valid_i. The sender holds ld_data_i/ld_last_i stable until the
// transfer. A cycle with ld_valid_i low is a bubble: the state and the counter
// hold for as long as the bubble lasts.
// -----------------------------------------------------------------------------
module inst_rom #(
    parameter int unsigned DEPTH     = 1024,            // power of 2, >= 2
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rv32core_pc_i,
    output logic [31:0] rom_inst_o,
    output logic        rom_inst_valid_o,
    output logic        rom_addr_err_o,
    input  logic        ld_start_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_valid_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        ld_busy_o,
    output logic        ld_done_o,
    output logic        ld_ovf_o,
    output logic [1:0]  ld_state_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra bit so the counter can hold DEPTH itself ("array full").
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

    ld_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          cnt_full;
    logic          ld_accept;

    // Reset does not touch the array. Simulation starts with every word
    // holding NOP_INST.
    logic [31:0] mem [DEPTH] = '{default: NOP_INST};

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    assign cnt_full   = (cnt_q == CW'(DEPTH));
    assign ld_ready_o = (state_q == ST_LOAD) && !cnt_full;
    assign ld_accept  = ld_valid_i && ld_ready_o;
    assign ld_busy_o  = (state_q == ST_LOAD);
    assign ld_done_o  = (state_q == ST_DONE);
    assign ld_ovf_o   = ovf_q;
    assign ld_state_o = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (ld_last_i) begin
                        state_d = ST_DONE;
                    end
                end else if (ld_valid_i && cnt_full) begin
                    // The sender still has data but there is no room left.
                    // Drop the word and end the load.
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The array write is separate from the state register, so the array
    // can map onto block RAM.
    always_ff @(posedge clk) begin
        if (!rst && ld_accept) begin
            mem[cnt_q[AW-1:0]] <= ld_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Fetch path
    // ------------------------------------------------------------------
    logic [31:0]   fetch_off;
    logic          fetch_bad;
    logic [AW-1:0] fetch_idx;

    // Modular subtraction: a PC below ADDR_BASE wraps to a large offset and
    // so falls out of range.
    assign fetch_off = rv32core_pc_i - ADDR_BASE;
    assign fetch_bad = (rv32core_pc_i[1:0] != 2'b00) ||
                       ((fetch_off >> 2) >= 32'(DEPTH));
    assign fetch_idx = fetch_off[AW+1:2];

    // Fetch is not blocked in DONE. The last word was written on the edge
    // that entered DONE, so the first fetch after DONE already returns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_inst_o       <= NOP_INST;
            rom_inst_valid_o <= 1'b0;
            rom_addr_err_o   <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            rom_inst_o       <= NOP_INST;
            rom_inst_valid_o <= 1'b0;
            rom_addr_err_o   <= 1'b0;
        end else if (fetch_bad) begin
            rom_inst_o       <= NOP_INST;
            rom_inst_valid_o <= 1'b0;
            rom_addr_err_o   <= 1'b1;
        end else begin
            rom_inst_o       <= mem[fetch_idx];
            rom_inst_valid_o <= 1'b1;
            rom_addr_err_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// -----------------------------------------------------------------------------
// tb_inst_rom: self-checking bench for inst_rom. It uses a small array
// (DEPTH=8) and a non-zero ADDR_BASE, so overflow and address wrap-around are
// cheap to reach.
// -----------------------------------------------------------------------------
module tb_inst_rom;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] pc = BASE;
  logic        ld_start_i = 1'b0;
  logic [31:0] ld_data_i = '0;
  logic        ld_valid_i = 1'b0;
  logic        ld_last_i = 1'b0;
  logic [31:0] rom_inst_o;
  logic        rom_inst_valid_o;
  logic        rom_addr_err_o;
  logic        ld_ready_o;
  logic        ld_busy_o;
  logic        ld_done_o;
  logic        ld_ovf_o;
  logic [1:0]  ld_state_o;

  inst_rom #(
    .DEPTH(DEPTH),
    .ADDR_BASE(BASE),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rv32core_pc_i(pc),
    .rom_inst_o(rom_inst_o),
    .rom_inst_valid_o(rom_inst_valid_o),
    .rom_addr_err_o(rom_addr_err_o),
    .ld_start_i(ld_start_i),
    .ld_data_i(ld_data_i),
    .ld_valid_i(ld_valid_i),
    .ld_last_i(ld_last_i),
    .ld_ready_o(ld_ready_o),
    .ld_busy_o(ld_busy_o),
    .ld_done_o(ld_done_o),
    .ld_ovf_o(ld_ovf_o),
    .ld_state_o(ld_state_o)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Array contents as the loader should have left them. A fetch result is
  // packed as {err, valid, inst}.
  logic [31:0] ref_mem [DEPTH];
  logic [33:0] exp_q [$];

  function automatic logic [33:0] fetch_exp(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    if ((a % 32'd4) != 0 || (off / 32'd4) >= 32'(DEPTH))
      return {1'b1, 1'b0, NOP};
    return {1'b0, 1'b1, ref_mem[off / 32'd4]};
  endfunction

  // ---------------- driver ----------------
  // One clock: inputs set before the call are sampled on the edge, and the
  // outputs are read 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = $urandom;
      ld_start_i = 1'($urandom_range(0, 1));
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_last_i = 1'($urandom_range(0, 1));
      ld_data_i = $urandom;
      step();
      checks++;
      if ({rom_addr_err_o, rom_inst_valid_o, rom_inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o}
          !== {2'b00, NOP, 4'b0000}) begin
        failures++;
        $display("FAIL reset_values got err=%b valid=%b inst=%h rdy=%b busy=%b done=%b ovf=%b exp all idle/NOP",
                 rom_addr_err_o, rom_inst_valid_o, rom_inst_o, ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o);
      end
    end
    rst = 1'b0;
    ld_start_i = 1'b0;
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
    pc = BASE;
  endtask

  task automatic test_init_fetch();
    logic [33:0] got;
    pc = BASE;
    step();
    got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
    checks++;
    if (got !== {2'b01, NOP}) begin
      failures++;
      $display("FAIL init_fetch_word0 got=%h exp=%h", got, {2'b01, NOP});
    end
    pc = BASE + 32'(4 * (DEPTH - 1));
    step();
    got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
    checks++;
    if (got !== {2'b01, NOP}) begin
      failures++;
      $display("FAIL init_fetch_lastword got=%h exp=%h", got, {2'b01, NOP});
    end
  endtask

  task automatic test_load_gapped();
    logic [31:0] w [3];
    logic [33:0] got;
    int acc;
    w = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
    acc = 0;
    pc = BASE;
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    for (int k = 0; k < 12 && acc < 3; k++) begin
      checks++;
      if ({ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o} !== 4'b1100) begin
        failures++;
        $display("FAIL gapped_load_status k=%0d got rdy/busy/done/ovf=%b state=%0d exp=1100",
                 k, {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o}, ld_state_o);
      end
      if (k > 0) begin
        got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
        checks++;
        if (got !== {2'b00, NOP}) begin
          failures++;
          $display("FAIL fetch_during_load k=%0d got=%h exp=%h", k, got, {2'b00, NOP});
        end
      end
      ld_valid_i = ((k % 2) == 0);
      ld_data_i = w[acc];
      ld_last_i = (acc == 2);
      step();
      if (ld_valid_i) begin
        ref_mem[acc] = w[acc];
        acc++;
      end
    end
    checks++;
    if (acc != 3 || {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o} !== 4'b0010) begin
      failures++;
      $display("FAIL gapped_load_done accepted=%0d got rdy/busy/done/ovf=%b state=%0d exp=0010",
               acc, {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o}, ld_state_o);
    end
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
    pc = BASE + 32'd8;
    step();
    got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
    checks++;
    if (got !== {2'b01, 32'h0020_81B3} || ld_done_o !== 1'b0) begin
      failures++;
      $display("FAIL fetch_after_done got=%h done=%b exp=%h done=0", got, ld_done_o, {2'b01, 32'h0020_81B3});
    end
    step();
    checks++;
    if ({ld_busy_o, ld_done_o} !== 2'b00) begin
      failures++;
      $display("FAIL done_single_pulse got busy/done=%b exp=00", {ld_busy_o, ld_done_o});
    end
  endtask

  task automatic test_bad_fetch();
    logic [31:0] pcs [8];
    logic [33:0] got, e;
    pcs = '{BASE + 32'd2, BASE + 32'd1, BASE + 32'(4 * DEPTH), BASE - 32'd4,
            32'hFFFF_FFFC, BASE + 32'(4 * DEPTH) + 32'h40, BASE + 32'(4 * (DEPTH - 1)) + 32'd3,
            BASE + 32'(4 * (DEPTH - 1))};
    for (int i = 0; i < 8; i++) begin
      pc = pcs[i];
      exp_q.push_back(fetch_exp(pcs[i]));
      step();
      got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL bad_fetch pc=%h got=%h exp=%h", pcs[i], got, e);
      end
    end
  endtask

  task automatic test_random_fetch();
    logic [31:0] a;
    logic [33:0] got, e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        2: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        default: a = $urandom;
      endcase
      pc = a;
      exp_q.push_back(fetch_exp(a));
      step();
      got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL random_fetch pc=%h got=%h exp=%h", a, got, e);
      end
    end
  endtask

  task automatic test_fetch_sweep();
    logic [31:0] a;
    logic [33:0] got, e;
    for (int i = 0; i < DEPTH; i++) begin
      a = BASE + 32'(4 * i);
      pc = a;
      exp_q.push_back(fetch_exp(a));
      step();
      got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL sweep_fetch word=%0d got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    // DEPTH words fill the array. The extra word arrives when it is full.
    for (int k = 0; k <= DEPTH; k++) begin
      checks++;
      if ({ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o} !== {(k < DEPTH), 3'b100}) begin
        failures++;
        $display("FAIL ovf_stream_status k=%0d got rdy/busy/done/ovf=%b state=%0d exp=%b",
                 k, {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o}, ld_state_o, {(k < DEPTH), 3'b100});
      end
      w = $urandom;
      ld_valid_i = 1'b1;
      ld_last_i = 1'b0;
      ld_data_i = w;
      step();
      if (k < DEPTH) ref_mem[k] = w;
    end
    ld_valid_i = 1'b0;
    checks++;
    if ({ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o} !== 4'b0011) begin
      failures++;
      $display("FAIL ovf_set_done got rdy/busy/done/ovf=%b exp=0011", {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({ld_busy_o, ld_done_o, ld_ovf_o} !== 3'b001) begin
        failures++;
        $display("FAIL ovf_sticky i=%0d got busy/done/ovf=%b exp=001", i, {ld_busy_o, ld_done_o, ld_ovf_o});
      end
    end
    test_fetch_sweep();
    // A new start clears the flag. A one-word load with last then ends cleanly.
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    checks++;
    if ({ld_busy_o, ld_ovf_o} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_cleared_on_start got busy/ovf=%b exp=10", {ld_busy_o, ld_ovf_o});
    end
    w = $urandom;
    ld_data_i = w;
    ld_valid_i = 1'b1;
    ld_last_i = 1'b1;
    step();
    ref_mem[0] = w;
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
    checks++;
    if ({ld_done_o, ld_ovf_o} !== 2'b10) begin
      failures++;
      $display("FAIL single_word_load got done/ovf=%b exp=10", {ld_done_o, ld_ovf_o});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    ld_start_i = 1'b1;
    step();
    // Random bubbles, plus start pulses that must be ignored mid-load.
    while (acc < 5 && guard < 200) begin
      checks++;
      if ({ld_ready_o, ld_busy_o, ld_done_o} !== 3'b110) begin
        failures++;
        $display("FAIL b2b_status acc=%0d got rdy/busy/done=%b state=%0d exp=110",
                 acc, {ld_ready_o, ld_busy_o, ld_done_o}, ld_state_o);
      end
      w = $urandom;
      ld_valid_i = 1'($urandom_range(0, 1));
      ld_start_i = 1'($urandom_range(0, 1));
      ld_data_i = w;
      ld_last_i = (acc == 4);
      step();
      if (ld_valid_i) begin
        ref_mem[acc] = w;
        acc++;
      end
      guard++;
    end
    ld_valid_i = 1'b0;
    ld_last_i = 1'b0;
    ld_start_i = 1'b1;
    checks++;
    if (acc != 5 || {ld_ready_o, ld_busy_o, ld_done_o} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_done accepted=%0d got rdy/busy/done=%b exp=001", acc, {ld_ready_o, ld_busy_o, ld_done_o});
    end
    step();
    ld_start_i = 1'b0;
    checks++;
    if ({ld_busy_o, ld_done_o} !== 2'b00) begin
      failures++;
      $display("FAIL start_in_done_ignored got busy/done=%b exp=00", {ld_busy_o, ld_done_o});
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] a, b, old2;
    logic [33:0] got;
    a = $urandom;
    b = $urandom;
    old2 = ref_mem[2];
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    ld_valid_i = 1'b1;
    ld_data_i = a;
    step();
    ld_data_i = b;
    step();
    ref_mem[0] = a;
    ref_mem[1] = b;
    ld_valid_i = 1'b0;
    checks++;
    if ({ld_ready_o, ld_busy_o} !== 2'b11) begin
      failures++;
      $display("FAIL midload_busy got rdy/busy=%b exp=11", {ld_ready_o, ld_busy_o});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o} !== 4'b0000) begin
      failures++;
      $display("FAIL midload_reset got rdy/busy/done/ovf=%b state=%0d exp=0000",
               {ld_ready_o, ld_busy_o, ld_done_o, ld_ovf_o}, ld_state_o);
    end
    pc = BASE + 32'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ld_busy_o, ld_done_o} !== 2'b00) begin
        failures++;
        $display("FAIL midload_no_done i=%0d got busy/done=%b exp=00", i, {ld_busy_o, ld_done_o});
      end
    end
    got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
    checks++;
    if (got !== {2'b01, b}) begin
      failures++;
      $display("FAIL midload_word1_kept got=%h exp=%h", got, {2'b01, b});
    end
    pc = BASE + 32'd8;
    step();
    got = {rom_addr_err_o, rom_inst_valid_o, rom_inst_o};
    checks++;
    if (got !== {2'b01, old2}) begin
      failures++;
      $display("FAIL midload_word2_old got=%h exp=%h", got, {2'b01, old2});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- main sequence + report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
    test_reset();
    test_init_fetch();
    test_load_gapped();
    test_bad_fetch();
    test_random_fetch();
    test_overflow();
    test_fetch_sweep();
    test_back_to_back();
    test_fetch_sweep();
    test_reset_mid_load();
    test_random_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction-memory responder on the far side of the core's fetch interface: accepts `rv32core_pc` and returns the instruction word.
- Synchronous read with 1-cycle latency, so the returned word lines up with the PC held in the IF/ID pipeline register.
- Includes a valid/ready boot-loader write port that fills the array sequentially from word 0. While loading, fetch returns NOP.
- Sits at core top level, beside the core; replaces the combinational ROM model.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of 2.
- ADDR_BASE, 32'h0000_0000, byte address mapped to word 0.
- NOP_INST, 32'h0000_0013, word returned for invalid or blocked fetches (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rv32core_pc_i  in  32  fetch byte address from the core.
- rom_inst_o  out  32  instruction for the PC sampled on the previous edge.
- rom_inst_valid_o  out  1  rom_inst_o holds a real array word.
- rom_addr_err_o  out  1  previous fetch was misaligned or out of range.
- ld_start_i  in  1  one-cycle pulse; begins a load at word 0.
- ld_data_i  in  32  word to write.
- ld_valid_i  in  1  ld_data_i is valid.
- ld_last_i  in  1  qualifies the final word of a load (sampled with ld_valid_i).
- ld_ready_o  out  1  loader can accept a word this cycle.
- ld_busy_o  out  1  FSM is in LOAD.
- ld_done_o  out  1  one-cycle pulse when a load terminates.
- ld_ovf_o  out  1  sticky: the last load overran DEPTH.

Behaviour:
- Clock/reset: one clock domain. Reset is synchronous, active-high.
- Reset values:
  - rom_inst_o=NOP_INST; rom_inst_valid_o=0; rom_addr_err_o=0.
  - ld_ready_o=0; ld_busy_o=0; ld_done_o=0; ld_ovf_o=0.
  - FSM=IDLE; word counter=0.
- Array: contents are not cleared by reset. Simulation initialises every word to NOP_INST.
- Fetch (FSM IDLE or DONE), evaluated each edge:
  - off = rv32core_pc_i - ADDR_BASE, computed in 32-bit modular arithmetic.
  - Misaligned (pc[1:0]!=0) or off>>2 >= DEPTH: next rom_inst_o=NOP_INST, valid=0, err=1.
  - Otherwise: next rom_inst_o=mem[off>>2], valid=1, err=0.
  - Latency is exactly 1 cycle. There is no stall input; the word is recomputed every cycle.
- Fetch during LOAD: rom_inst_o=NOP_INST, valid=0, err=0.
- FSM states:
  - IDLE: ld_start_i -> LOAD. Counter=0, ld_ovf_o cleared.
  - LOAD: ld_ready_o=1 while counter<DEPTH. On accept (ld_valid_i & ld_ready_o): mem[counter]<=ld_data_i, counter+1.
    - Accept with ld_last_i=1 -> DONE.
    - ld_valid_i while counter==DEPTH (ready=0): set ld_ovf_o, -> DONE; the word is not written.
  - DONE: ld_done_o=1 for this single cycle -> IDLE.
- ld_busy_o=1 only in LOAD. ld_ready_o=0 outside LOAD.
- ld_start_i is ignored in LOAD and DONE.
- Counter is log2(DEPTH)+1 bits wide so that the value DEPTH is representable; there is no wrap-around.
- Fetch in the first cycle after DONE returns the newly written data.
- Reset mid-load: FSM returns to IDLE, counter=0. Words already written are kept; no ld_done_o pulse.
- Bubble handshake: ld_valid_i=0 in LOAD holds counter and state indefinitely.

Test Plan:
- Reset, then pc=0x0 -> rom_inst_o=0x00000013 and valid=1 on the next edge (init NOP); during reset all outputs at reset values.
- Start pulse, load 0x00500093, 0x00A00113, 0x002081B3 (last on 3rd) with ld_valid_i gapped on alternate cycles:
  - ld_busy_o high throughout; ld_done_o pulses once, 1 cycle after the 3rd accept.
  - Then pc=0x8 -> rom_inst_o=0x002081B3, valid=1, exactly 1 cycle later.
- Fetch during LOAD with pc=0x0 -> rom_inst_o=NOP, valid=0, err=0.
- pc=0x2 -> err=1, NOP, valid=0.
- pc=ADDR_BASE+4*DEPTH -> err=1, NOP, valid=0.
- DEPTH=4: stream 5 words without last:
  - First 4 written; ready drops at counter 4; 5th valid sets ld_ovf_o=1 and pulses ld_done_o.
  - ld_ovf_o stays 1 until the next start.
- Assert rst after 2 of 4 words loaded:
  - FSM IDLE, no done pulse.
  - Fetch pc=0x4 returns the 2nd word.
  - Fetch pc=0x8 returns the old contents.
